// File: rtl/packet_serializer.sv
// Frame serializer: latches an address/payload request, obtains a CRC from an
// external stage, then shifts {preamble, address, payload, crc} out MSB first.
module packet_serializer #(
  parameter int unsigned BIT_PERIOD  = 8,
  parameter logic [7:0]  PREAMBLE    = 8'b10101011,
  parameter int unsigned CRC_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [18:0] tr_address,
  input  logic [35:0] tr_data,
  output logic        crc_start,
  output logic [18:0] crc_address,
  output logic [35:0] crc_data,
  input  logic        crc_done,
  input  logic [15:0] crc_r,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        crc_error
);

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 36;
  localparam int unsigned CRC_W   = 16;
  localparam int unsigned FRAME_W = 8 + ADDR_W + DATA_W + CRC_W;
  localparam int unsigned WAIT_W  = $clog2(CRC_TIMEOUT + 1);

  localparam logic [7:0]        BIT_LAST  = 8'(BIT_PERIOD - 1);
  localparam logic [6:0]        CNT_LAST  = 7'(FRAME_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CRC_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CRC_START = 2'd1,
    CRC_WAIT  = 2'd2,
    SEND      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   crc_address_q, crc_address_d;
  logic [DATA_W-1:0]   crc_data_q, crc_data_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]          bit_tmr_q, bit_tmr_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d;
  logic                frame_done_q, frame_done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      crc_address_q <= '0;
      crc_data_q    <= '0;
      shreg_q       <= '0;
      wait_cnt_q    <= '0;
      bit_tmr_q     <= '0;
      bit_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_address_q <= crc_address_d;
      crc_data_q    <= crc_data_d;
      shreg_q       <= shreg_d;
      wait_cnt_q    <= wait_cnt_d;
      bit_tmr_q     <= bit_tmr_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    crc_address_d = crc_address_q;
    crc_data_d    = crc_data_q;
    shreg_d       = shreg_q;
    wait_cnt_d    = wait_cnt_q;
    bit_tmr_d     = bit_tmr_q;
    bit_cnt_d     = bit_cnt_q;
    frame_done_d  = 1'b0;
    crc_error     = 1'b0;

    case (state_q)
      IDLE: begin
        if (send) begin
          crc_address_d = tr_address;
          crc_data_d    = tr_data;
          state_d       = CRC_START;
        end
      end

      CRC_START: begin
        wait_cnt_d = '0;
        state_d    = CRC_WAIT;
      end

      // crc_done is tested first so it wins over a timeout in the same cycle
      CRC_WAIT: begin
        if (crc_done) begin
          shreg_d   = {PREAMBLE, crc_address_q, crc_data_q, crc_r};
          bit_tmr_d = '0;
          bit_cnt_d = '0;
          state_d   = SEND;
        end else if (wait_cnt_q == WAIT_LAST) begin
          crc_error = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      SEND: begin
        if (bit_tmr_q == BIT_LAST) begin
          bit_tmr_d = '0;
          if (bit_cnt_q == CNT_LAST) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line outputs decode the state register so reset drops them without a clock
  assign tx_valid    = (state_q == SEND);
  assign tx_bit      = tx_valid & shreg_q[FRAME_W-1];
  assign busy        = (state_q != IDLE);
  assign crc_start   = (state_q == CRC_START);
  assign frame_done  = frame_done_q;
  assign crc_address = crc_address_q;
  assign crc_data    = crc_data_q;

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: nominal frame, CRC timeout, timeout/done
// collision, busy blocking, asynchronous mid-frame reset and back-to-back frames.
module tb_packet_serializer;

  localparam int BP      = 4;
  localparam int TIMEOUT = 80;
  localparam logic [7:0] PRE = 8'b10101011;

  logic        clock;
  logic        reset;
  logic        send;
  logic [18:0] tr_address;
  logic [35:0] tr_data;
  logic        crc_start;
  logic [18:0] crc_address;
  logic [35:0] crc_data;
  logic        crc_done;
  logic [15:0] crc_r;
  logic        tx_bit;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic        crc_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_crc_start = 0;
  int n_frame_done = 0;
  int n_crc_error = 0;

  packet_serializer #(
    .BIT_PERIOD (BP),
    .CRC_TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .send       (send),
    .tr_address (tr_address),
    .tr_data    (tr_data),
    .crc_start  (crc_start),
    .crc_address(crc_address),
    .crc_data   (crc_data),
    .crc_done   (crc_done),
    .crc_r      (crc_r),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_error  (crc_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (crc_start)  n_crc_start  <= n_crc_start + 1;
    if (frame_done) n_frame_done <= n_frame_done + 1;
    if (crc_error)  n_crc_error  <= n_crc_error + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first CRC_WAIT cycle.
  task automatic start_frame(input logic [18:0] a, input logic [35:0] d, input bit hold);
    tr_address = a;
    tr_data    = d;
    send       = 1'b1;
    @(negedge clock);
    check_eq("crc_start_hi", 80'({crc_start, busy}), 80'(2'b11));
    if (!hold) send = 1'b0;
    @(negedge clock);
    check_eq("crc_start_lo", 80'(crc_start), 80'(0));
    check_eq("latch_addr", 80'(crc_address), 80'(a));
    check_eq("latch_data", 80'(crc_data), 80'(d));
  endtask

  // Answers in CRC_WAIT cycle index k; returns at the negedge of the first SEND cycle.
  task automatic crc_reply(input int k, input logic [15:0] r);
    for (int i = 0; i < k; i++) begin
      check_eq("crc_wait", 80'({tx_valid, crc_error, crc_start}), 80'(0));
      @(negedge clock);
    end
    crc_done = 1'b1;
    crc_r    = r;
    #1;
    check_eq("done_prio", 80'(crc_error), 80'(0));
    @(negedge clock);
    crc_done = 1'b0;
  endtask

  // Checks every clock of the 79-bit frame; optionally injects a send pulse at
  // bit inj_n, or asserts reset mid-period of bit abort_n and returns early.
  task automatic check_frame(input logic [78:0] exp, input int inj_n, input int abort_n);
    for (int n = 0; n < 79; n++) begin
      for (int t = 0; t < BP; t++) begin
        check_eq("tx_bit", 80'({tx_valid, tx_bit}), 80'({1'b1, exp[78-n]}));
        if (n == abort_n && t == 1) begin
          #2 reset = 1'b1;
          #1 check_eq("rst_async", 80'({tx_valid, tx_bit, busy}), 80'(0));
          return;
        end
        if (n == inj_n && t == 0) begin
          send       = 1'b1;
          tr_address = 19'h0F0F0;
          tr_data    = 36'hFEDCBA987;
        end else if (n == inj_n && t == 1) begin
          send = 1'b0;
        end
        @(negedge clock);
      end
    end
    check_eq("frame_end", 80'({tx_valid, tx_bit, frame_done, busy}), 80'(4'b0010));
    check_eq("addr_stable", 80'(crc_address), 80'(exp[70:52]));
    check_eq("data_stable", 80'(crc_data), 80'(exp[51:16]));
  endtask

  initial begin
    int s0;
    reset      = 1'b1;
    send       = 1'b0;
    crc_done   = 1'b0;
    crc_r      = '0;
    tr_address = '0;
    tr_data    = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_ctrl", 80'({tx_bit, tx_valid, busy, crc_start, frame_done, crc_error}), 80'(0));
    check_eq("rst_regs", 80'({crc_address, crc_data}), 80'(0));
    reset = 1'b0;

    // Nominal frame
    s0 = n_frame_done;
    start_frame(19'h5A5A5, 36'h123456789, 1'b0);
    crc_reply(56, 16'hBEEF);
    check_frame({PRE, 19'h5A5A5, 36'h123456789, 16'b1011111011101111}, -1, -1);
    @(negedge clock);
    check_eq("done_pulse", 80'({frame_done, busy, tx_valid}), 80'(0));
    check_eq("done_count", 80'(n_frame_done - s0), 80'(1));

    // CRC timeout
    s0 = n_crc_error;
    start_frame(19'h11111, 36'h222222222, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      check_eq("to_wait", 80'({crc_error, tx_valid, busy}), 80'(3'b001));
      @(negedge clock);
    end
    check_eq("to_err", 80'({crc_error, tx_valid, busy}), 80'(3'b101));
    @(negedge clock);
    check_eq("to_after", 80'({crc_error, tx_valid, busy}), 80'(0));
    check_eq("to_count", 80'(n_crc_error - s0), 80'(1));

    // crc_done arriving on the timeout cycle
    s0 = n_crc_error;
    start_frame(19'h3C3C3, 36'h0F0F0F0F0, 1'b0);
    crc_reply(TIMEOUT, 16'h1234);
    check_frame({PRE, 19'h3C3C3, 36'h0F0F0F0F0, 16'h1234}, -1, -1);
    @(negedge clock);
    check_eq("coll_noerr", 80'(n_crc_error - s0), 80'(0));

    // Second request during a frame is ignored
    s0 = n_crc_start;
    start_frame(19'h00001, 36'h800000001, 1'b0);
    crc_reply(5, 16'hC0DE);
    check_frame({PRE, 19'h00001, 36'h800000001, 16'hC0DE}, 10, -1);
    repeat (3) begin
      @(negedge clock);
      check_eq("blk_idle", 80'({busy, crc_start}), 80'(0));
    end
    check_eq("blk_starts", 80'(n_crc_start - s0), 80'(1));

    // Asynchronous reset during bit 40, then a clean frame
    start_frame(19'h7FFFF, 36'hAAAAAAAAA, 1'b0);
    crc_reply(3, 16'hFACE);
    check_frame({PRE, 19'h7FFFF, 36'hAAAAAAAAA, 16'hFACE}, -1, 40);
    @(negedge clock);
    check_eq("rst_hold", 80'({tx_valid, tx_bit, busy, crc_address, crc_data}), 80'(0));
    @(negedge clock);
    reset = 1'b0;
    start_frame(19'h2468A, 36'h13579BDF0, 1'b0);
    crc_reply(10, 16'h0F0F);
    check_frame({PRE, 19'h2468A, 36'h13579BDF0, 16'h0F0F}, -1, -1);
    @(negedge clock);

    // Three back-to-back frames with send held high
    s0 = n_frame_done;
    start_frame(19'h55555, 36'h987654321, 1'b1);
    crc_reply(8, 16'h0001);
    check_frame({PRE, 19'h55555, 36'h987654321, 16'h0001}, -1, -1);
    start_frame(19'h55555, 36'h987654321, 1'b1);
    crc_reply(8, 16'h8002);
    check_frame({PRE, 19'h55555, 36'h987654321, 16'h8002}, -1, -1);
    start_frame(19'h55555, 36'h987654321, 1'b1);
    crc_reply(8, 16'h4004);
    check_frame({PRE, 19'h55555, 36'h987654321, 16'h4004}, -1, -1);
    send = 1'b0;
    @(negedge clock);
    check_eq("b2b_idle", 80'({busy, crc_start}), 80'(0));
    check_eq("b2b_count", 80'(n_frame_done - s0), 80'(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
